// File: rtl/byte_arb_pkg.sv
// Shared types, default parameters and helpers for the byte stream arbiter.
package byte_arb_pkg;

  typedef enum logic [1:0] {StIdle, StWaitSof, StBusy, StGap} state_t;

  localparam int unsigned DefNumPorts = 4;
  localparam int unsigned DefIfg      = 12;
  localparam int unsigned DefStartTo  = 16;
  localparam int unsigned DefMaxLen   = 2048;

  // Width able to hold 0..n-1, never less than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned next_ptr(int unsigned sel, int unsigned n);
    return (sel + 1 >= n) ? 0 : sel + 1;
  endfunction

endpackage

// File: rtl/byte_stream_arbiter_if.sv
// Requester-facing and pipeline-facing signals of the byte stream arbiter.
interface byte_stream_arbiter_if
  import byte_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = DefNumPorts
);
  localparam int unsigned IdxW = idx_width(NUM_PORTS);

  logic [NUM_PORTS-1:0]   req;
  logic [NUM_PORTS-1:0]   gnt;
  logic [NUM_PORTS*8-1:0] rxd;
  logic [NUM_PORTS-1:0]   rx_dv;
  logic [7:0]             txd;
  logic                   tx_en;
  logic [IdxW-1:0]        active_port;
  logic                   err_timeout;
  logic                   err_overlen;

  // master is the arbiter itself; slave is the requester/pipeline side.
  modport master (
    input  req, rxd, rx_dv,
    output gnt, txd, tx_en, active_port, err_timeout, err_overlen
  );

  modport slave (
    output req, rxd, rx_dv,
    input  gnt, txd, tx_en, active_port, err_timeout, err_overlen
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr, wrapping.
module rr_pick
  import byte_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = DefNumPorts
) (
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [idx_width(NUM_PORTS)-1:0] ptr,
  output logic                            valid,
  output logic [NUM_PORTS-1:0]            onehot,
  output logic [idx_width(NUM_PORTS)-1:0] idx
);
  localparam int unsigned IdxW = idx_width(NUM_PORTS);

  always_comb begin
    int unsigned p;
    logic [IdxW-1:0] pi;
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    p      = 0;
    pi     = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      p = 32'(ptr) + k;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      pi = IdxW'(p);
      if (!valid && req[pi]) begin
        valid      = 1'b1;
        onehot[pi] = 1'b1;
        idx        = pi;
      end
    end
  end

endmodule

// File: rtl/byte_stream_arbiter.sv
// Frame-by-frame round-robin arbiter muxing NUM_PORTS byte streams onto one
// registered txd/tx_en datapath, with inter-frame gap, start timeout and length cap.
module byte_stream_arbiter
  import byte_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = DefNumPorts,
  parameter int unsigned IFG       = DefIfg,
  parameter int unsigned START_TO  = DefStartTo,
  parameter int unsigned MAX_LEN   = DefMaxLen
) (
  input logic                   clk,
  input logic                   rst,
  byte_stream_arbiter_if.master bus
);
  localparam int unsigned IdxW = idx_width(NUM_PORTS);
  localparam int unsigned TmrW = idx_width(START_TO);
  localparam int unsigned GapW = idx_width(IFG);
  localparam int unsigned LenW = $clog2(MAX_LEN + 1);

  state_t                state_q, state_d;
  logic [NUM_PORTS-1:0]  gnt_q, gnt_d;
  logic [IdxW-1:0]       sel_q, sel_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TmrW-1:0]       timer_q, timer_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic [LenW-1:0]       len_q, len_d;
  logic [7:0]            txd_q, txd_d;
  logic                  tx_en_q, tx_en_d;
  logic                  err_to_q, err_to_d;
  logic                  err_ol_q, err_ol_d;

  logic                  pick_valid;
  logic [NUM_PORTS-1:0]  pick_onehot;
  logic [IdxW-1:0]       pick_idx;
  logic                  cur_dv;
  logic                  cur_req;
  logic [7:0]            cur_byte;
  logic [IdxW-1:0]       ptr_after;

  rr_pick #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr_pick (
    .req    (bus.req),
    .ptr    (rr_ptr_q),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign cur_dv    = bus.rx_dv[sel_q];
  assign cur_req   = bus.req[sel_q];
  assign cur_byte  = bus.rxd[{sel_q, 3'b000} +: 8];
  assign ptr_after = IdxW'(next_ptr(32'(sel_q), NUM_PORTS));

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    timer_d  = timer_q;
    gap_d    = gap_q;
    len_d    = len_q;
    txd_d    = '0;
    tx_en_d  = 1'b0;
    err_to_d = 1'b0;
    err_ol_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StWaitSof;
          gnt_d   = pick_onehot;
          sel_d   = pick_idx;
          timer_d = '0;
        end
      end
      StWaitSof: begin
        txd_d   = cur_byte;
        tx_en_d = cur_dv;
        if (cur_dv) begin
          state_d = StBusy;
          len_d   = LenW'(1);
        end else if (!cur_req) begin
          gnt_d    = '0;
          rr_ptr_d = ptr_after;
          state_d  = StIdle;
        end else if (timer_q == TmrW'(START_TO - 1)) begin
          err_to_d = 1'b1;
          gnt_d    = '0;
          rr_ptr_d = ptr_after;
          state_d  = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StBusy: begin
        if (cur_dv && (len_q < LenW'(MAX_LEN))) begin
          txd_d   = cur_byte;
          tx_en_d = 1'b1;
          len_d   = len_q + 1'b1;
        end else begin
          // Either end of frame or a truncated byte, which is never forwarded.
          if (cur_dv) err_ol_d = 1'b1;
          else        txd_d    = cur_byte;
          gnt_d    = '0;
          rr_ptr_d = ptr_after;
          gap_d    = '0;
          if (IFG == 0) state_d = StIdle;
          else          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == GapW'(IFG - 1)) state_d = StIdle;
        else                         gap_d   = gap_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      timer_q  <= '0;
      gap_q    <= '0;
      len_q    <= '0;
      txd_q    <= '0;
      tx_en_q  <= 1'b0;
      err_to_q <= 1'b0;
      err_ol_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      timer_q  <= timer_d;
      gap_q    <= gap_d;
      len_q    <= len_d;
      txd_q    <= txd_d;
      tx_en_q  <= tx_en_d;
      err_to_q <= err_to_d;
      err_ol_q <= err_ol_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.active_port = sel_q;
  assign bus.txd         = txd_q;
  assign bus.tx_en       = tx_en_q;
  assign bus.err_timeout = err_to_q;
  assign bus.err_overlen = err_ol_q;

endmodule

// File: tb/tb_byte_stream_arbiter.sv
// Bench for byte_stream_arbiter: rr_pick vector table, directed frame scenarios,
// and randomized traffic checked every cycle against a behavioural model.
module tb_byte_stream_arbiter;
  localparam int NP  = 4;
  localparam int IFG = 12;
  localparam int STO = 16;
  localparam int ML  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  byte_stream_arbiter_if #(.NUM_PORTS(NP)) bus ();

  byte_stream_arbiter #(
    .NUM_PORTS (NP),
    .IFG       (IFG),
    .START_TO  (STO),
    .MAX_LEN   (ML)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [3:0] pk_req;
  logic [1:0] pk_ptr;
  logic       pk_valid;
  logic [3:0] pk_onehot;
  logic [1:0] pk_idx;

  rr_pick #(.NUM_PORTS(NP)) u_pick (
    .req    (pk_req),
    .ptr    (pk_ptr),
    .valid  (pk_valid),
    .onehot (pk_onehot),
    .idx    (pk_idx)
  );

  typedef struct packed {
    logic [3:0] req;
    logic [1:0] ptr;
    logic       valid;
    logic [3:0] onehot;
    logic [1:0] idx;
  } pick_vec_t;
  pick_vec_t vecs [11];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: who owns the bus, how long it waited, bytes sent, gap left.
  int         m_owner = -1;
  bit         m_started = 0;
  int         m_wait = 0, m_bytes = 0, m_gap = 0, m_ptr = 0;
  logic [3:0] e_gnt = '0;
  logic [7:0] e_txd = '0;
  bit         e_tx_en = 0, e_to = 0, e_ol = 0;
  int         e_ap = 0;

  task automatic model_release(int gap);
    m_ptr   = (m_owner + 1) % NP;
    m_owner = -1;
    m_gap   = gap;
  endtask

  task automatic model_step();
    logic [7:0] b;
    bit dv;
    if (rst) begin
      m_owner = -1; m_started = 0; m_wait = 0; m_bytes = 0; m_gap = 0; m_ptr = 0;
      e_gnt = '0; e_txd = '0; e_tx_en = 0; e_to = 0; e_ol = 0; e_ap = 0;
      return;
    end
    e_txd = '0; e_tx_en = 0; e_to = 0; e_ol = 0;
    if (m_owner >= 0) begin
      dv = bus.rx_dv[m_owner];
      b  = bus.rxd[m_owner*8 +: 8];
      if (!m_started) begin
        e_txd = b;
        e_tx_en = dv;
        if (dv) begin
          m_started = 1;
          m_bytes = 1;
        end else if (!bus.req[m_owner]) model_release(0);
        else if (m_wait == STO - 1) begin
          e_to = 1;
          model_release(0);
        end else m_wait++;
      end else if (dv && m_bytes < ML) begin
        e_txd = b; e_tx_en = 1; m_bytes++;
      end else if (!dv) begin
        e_txd = b;
        model_release(IFG);
      end else begin
        e_ol = 1;
        model_release(IFG);
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 0; k < NP; k++) begin
        int p = (m_ptr + k) % NP;
        if (m_owner < 0 && bus.req[p]) begin
          m_owner = p; m_started = 0; m_wait = 0;
        end
      end
    end
    e_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    if (m_owner >= 0) e_ap = m_owner;
  endtask

  // Observation bookkeeping for the directed scenarios.
  logic [7:0] obs[$];
  int         idle_runs[$];
  bit         seen_tx = 0, prev_tx_en = 0, saw_ff = 0;
  int         last_tx_cyc = 0, fall_cyc = 0, grant_cyc = 0, to_cnt = 0, ol_cnt = 0;
  logic [3:0] prev_gnt = '0;

  task automatic tick();
    logic [16:0] act, exp;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    act = {bus.gnt, bus.txd, bus.tx_en, bus.active_port, bus.err_timeout, bus.err_overlen};
    exp = {e_gnt, e_txd, e_tx_en, 2'(e_ap), e_to, e_ol};
    check("cycle_model", 32'(act), 32'(exp));
    if (bus.tx_en) begin
      obs.push_back(bus.txd);
      if (!prev_tx_en && seen_tx) idle_runs.push_back(cyc - last_tx_cyc - 1);
      last_tx_cyc = cyc;
      seen_tx = 1;
    end
    if (bus.txd == 8'hFF) saw_ff = 1;
    if (bus.gnt == 0 && prev_gnt != 0) fall_cyc = cyc;
    if (bus.gnt != 0 && prev_gnt == 0) grant_cyc = cyc;
    to_cnt += int'(bus.err_timeout);
    ol_cnt += int'(bus.err_overlen);
    prev_tx_en = bus.tx_en;
    prev_gnt = bus.gnt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0; bus.rx_dv = '0; bus.rxd = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_gnt_any(int budget);
    int n = 0;
    while (bus.gnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check("wait_gnt", 32'(bus.gnt != 0), 1);
  endtask

  task automatic send_bytes(int p, int n, logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      bus.rx_dv[p] = 1'b1;
      bus.rxd[p*8 +: 8] = base + 8'(i);
      tick();
    end
    bus.rx_dv[p] = 1'b0;
    tick();
  endtask

  initial begin
    int held;
    int rate;
    rst = 1'b1;
    bus.req = '0; bus.rx_dv = '0; bus.rxd = '0;

    vecs[0]  = '{4'b0000, 2'd0, 1'b0, 4'b0000, 2'd0};
    vecs[1]  = '{4'b0001, 2'd0, 1'b1, 4'b0001, 2'd0};
    vecs[2]  = '{4'b1111, 2'd0, 1'b1, 4'b0001, 2'd0};
    vecs[3]  = '{4'b1111, 2'd2, 1'b1, 4'b0100, 2'd2};
    vecs[4]  = '{4'b1111, 2'd3, 1'b1, 4'b1000, 2'd3};
    vecs[5]  = '{4'b0011, 2'd2, 1'b1, 4'b0001, 2'd0};
    vecs[6]  = '{4'b1010, 2'd3, 1'b1, 4'b1000, 2'd3};
    vecs[7]  = '{4'b1010, 2'd0, 1'b1, 4'b0010, 2'd1};
    vecs[8]  = '{4'b0101, 2'd2, 1'b1, 4'b0100, 2'd2};
    vecs[9]  = '{4'b0100, 2'd3, 1'b1, 4'b0100, 2'd2};
    vecs[10] = '{4'b1000, 2'd1, 1'b1, 4'b1000, 2'd3};
    for (int i = 0; i < 11; i++) begin
      pk_req = vecs[i].req;
      pk_ptr = vecs[i].ptr;
      #1;
      check($sformatf("rr_pick[%0d]", i), 32'({pk_valid, pk_onehot, pk_idx}),
            32'({vecs[i].valid, vecs[i].onehot, vecs[i].idx}));
    end

    // Reset state
    do_reset();
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_tx_en", 32'(bus.tx_en), 0);
    check("rst_txd", 32'(bus.txd), 0);
    check("rst_active_port", 32'(bus.active_port), 0);
    check("rst_errs", 32'({bus.err_timeout, bus.err_overlen}), 0);

    // Single port frame and gap before re-grant
    bus.req = 4'b0001;
    tick();
    check("single_gnt", 32'(bus.gnt), 32'b0001);
    obs.delete();
    send_bytes(0, 5, 8'h11);
    check("single_count", 32'(obs.size()), 5);
    for (int i = 0; i < 5 && i < obs.size(); i++)
      check($sformatf("single_byte%0d", i), 32'(obs[i]), 32'(8'h11 + i));
    check("single_gnt_fall", 32'(bus.gnt), 0);
    wait_gnt_any(40);
    check("single_regrant_delay", 32'(grant_cyc - fall_cyc), 32'(IFG + 1));
    bus.req = '0;
    tick();
    tick();

    // Round robin with all ports requesting
    do_reset();
    seen_tx = 0;
    idle_runs.delete();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt_any(40);
      check($sformatf("rr_port%0d", k), 32'(bus.active_port), 32'(k % NP));
      check($sformatf("rr_onehot%0d", k), 32'(bus.gnt), 32'(1 << (k % NP)));
      send_bytes(k % NP, 3, 8'(8'h40 + 8'(k * 16)));
    end
    bus.req = '0;
    check("rr_runs", 32'(idle_runs.size()), 4);
    foreach (idle_runs[i]) check($sformatf("rr_ifg%0d", i), 32'(idle_runs[i] >= IFG), 1);
    for (int i = 0; i < 16; i++) tick();

    // Start timeout, next grant to port 3
    do_reset();
    to_cnt = 0;
    bus.req = 4'b1100;
    wait_gnt_any(10);
    check("to_gnt", 32'(bus.gnt), 32'b0100);
    held = 1;
    while (held < 40) begin
      tick();
      if (bus.gnt[2]) held++;
      else break;
    end
    check("to_held", 32'(held), 32'(STO));
    check("to_pulse", 32'(bus.err_timeout), 1);
    check("to_gnt_drop", 32'(bus.gnt), 0);
    tick();
    check("to_pulse_end", 32'(bus.err_timeout), 0);
    check("to_next_port3", 32'(bus.gnt), 32'b1000);
    bus.req = '0;
    tick();
    tick();
    check("to_count", 32'(to_cnt), 1);

    // Overlength truncation
    do_reset();
    ol_cnt = 0;
    obs.delete();
    bus.req = 4'b0010;
    wait_gnt_any(10);
    for (int i = 0; i < 12; i++) begin
      bus.rx_dv[1] = 1'b1;
      bus.rxd[15:8] = 8'hA0 + 8'(i);
      tick();
    end
    bus.rx_dv[1] = 1'b0;
    bus.req = '0;
    for (int i = 0; i < 20; i++) tick();
    check("ol_count", 32'(obs.size()), 32'(ML));
    foreach (obs[i]) check($sformatf("ol_byte%0d", i), 32'(obs[i]), 32'(8'hA0 + i));
    check("ol_pulses", 32'(ol_cnt), 1);

    // Isolation from a noisy non-granted port, then reset mid-frame
    do_reset();
    bus.req = 4'b0001;
    wait_gnt_any(10);
    send_bytes(0, 2, 8'h21);
    wait_gnt_any(40);
    saw_ff = 0;
    bus.req[3] = 1'b1;
    bus.rxd[31:24] = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      bus.rx_dv[0] = 1'b1;
      bus.rxd[7:0] = 8'h30 + 8'(i);
      bus.rx_dv[3] = i[0];
      tick();
    end
    check("iso_no_ff", 32'(saw_ff), 0);
    rst = 1'b1;
    tick();
    check("rst_mid_tx_en", 32'(bus.tx_en), 0);
    check("rst_mid_gnt", 32'(bus.gnt), 0);
    rst = 1'b0;
    bus.rx_dv = '0;
    bus.req = 4'b0011;
    tick();
    check("rst_mid_ptr0", 32'(bus.gnt), 32'b0001);
    bus.req = '0;

    // Randomized traffic against the model
    do_reset();
    rate = 3;
    for (int c = 0; c < 6000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(2))
          0: rate = 1;
          1: rate = 3;
          default: rate = 15;
        endcase
      end
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(7) == 0) bus.req[p] = ~bus.req[p];
        if ($urandom_range(rate) == 0) bus.rx_dv[p] = ~bus.rx_dv[p];
        bus.rxd[p*8 +: 8] = 8'($urandom);
      end
      rst = ($urandom_range(999) == 0);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/byte_stream_arbiter.md
Name: byte_stream_arbiter

Overview:
Shares the single 8-bit txd/tx_en byte-stream datapath between NUM_PORTS requesters on a frame-by-frame basis. Each requester raises req, waits for its one-hot gnt, then drives rxd/rx_dv for exactly one frame, defined as a contiguous rx_dv-high run. The block uses round-robin fairness and enforces an inter-frame gap, a start-of-frame timeout and a maximum frame length. It sits in front of the registered byte pipeline and drives it.

Parameters:
NUM_PORTS, 4, number of requesters (2..16)
IFG, 12, idle cycles enforced after each frame before re-arbitration (0 allowed)
START_TO, 16, cycles a granted port may take to raise rx_dv before grant is revoked (>=1)
MAX_LEN, 2048, maximum bytes per frame; the byte counter width is $clog2(MAX_LEN+1)

Ports:
clk          input   1                 clock, all logic on rising edge
rst          input   1                 synchronous active-high reset
req          input   NUM_PORTS         per-port request, level
gnt          output  NUM_PORTS         one-hot grant, registered
rxd          input   NUM_PORTS*8       per-port data, port i in bits [8i+7:8i]
rx_dv        input   NUM_PORTS         per-port data valid
txd          output  8                 muxed data, registered
tx_en        output  1                 muxed valid, registered
active_port  output  $clog2(NUM_PORTS) index of granted port, held while gnt!=0
err_timeout  output  1                 1-cycle pulse on start timeout
err_overlen  output  1                 1-cycle pulse on frame truncation

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset (sampled rst=1): gnt=0, txd=0, tx_en=0, active_port=0, err_*=0, state=IDLE, rr_ptr=0, counters=0.
- Reset mid-frame has the same effect. The frame is dropped and tx_en is low on the next cycle.
- States: IDLE, WAIT_SOF, BUSY, GAP.
- IDLE: if req!=0, select the first requesting port at or after rr_ptr, searching upward and wrapping modulo NUM_PORTS. On the next edge: gnt[sel]=1, active_port=sel, timer=0, state=WAIT_SOF. If req==0, stay in IDLE.
- WAIT_SOF, rx_dv[sel]=1: state=BUSY. This byte is forwarded (see datapath) and len=1.
- WAIT_SOF, req[sel]=0 with rx_dv[sel]=0: silent release. Next edge gnt=0, rr_ptr=sel+1 (wrap), state=IDLE, no error.
- WAIT_SOF, timer reaches START_TO-1 with rx_dv[sel] still 0: next edge err_timeout=1 for one cycle, gnt=0, rr_ptr=sel+1, state=IDLE. No gap is applied because no data was sent.
- BUSY, rx_dv[sel]=1 and len<MAX_LEN: forward the byte and increment len. req is ignored while BUSY.
- BUSY, rx_dv[sel]=0 (end of frame): next edge gnt=0, rr_ptr=sel+1, state=GAP (or IDLE if IFG=0).
- BUSY, rx_dv[sel]=1 and len==MAX_LEN: truncate. This byte is not forwarded. Next edge err_overlen=1 for one cycle, gnt=0, rr_ptr=sel+1, state=GAP.
- Truncation: remaining bytes from the port are ignored because it is no longer granted.
- GAP: count IFG cycles, then go to IDLE. A new grant can appear at earliest IFG+1 cycles after gnt falls.
- Datapath, 1-cycle latency:
  - When state is WAIT_SOF or BUSY and the byte is not truncated: txd<=rxd[sel], tx_en<=rx_dv[sel].
  - Otherwise: tx_en<=0, txd<=0.
- rx_dv and rxd of non-granted ports are never visible on txd/tx_en.
- gnt is always one-hot or zero. active_port is valid only when gnt!=0 and holds its last value otherwise.
- Simultaneous requests: strict rotation from rr_ptr. A port that just finished has the lowest priority next round.
- Bytes per frame are counted independently of IFG. Counters saturate and never wrap.

Decomposition:
- Package byte_arb_pkg holds:
  - the state_t enum (IDLE, WAIT_SOF, BUSY, GAP);
  - default parameter constants;
  - the function next_ptr(sel, n) implementing modulo increment.
- One sub-module, rr_pick: combinational round-robin selector. Inputs are req and rr_ptr. Outputs are a valid flag, a one-hot result and an index. It is unit-testable on its own.
- FSM, counters and the output mux stay in byte_stream_arbiter.

Test Plan:
- Single port: req[0]=1, port 0 sends 5 bytes 0x11..0x15 after gnt. Required: gnt=0001 one cycle after req; txd shows 0x11..0x15 with tx_en high for exactly 5 cycles, each one cycle after rx_dv; gnt falls; next grant no earlier than IFG+1 cycles later.
- Round-robin: req=1111 held, each port sends 3-byte frames. Required: grant order 0,1,2,3,0. Each frame is separated by >=12 idle tx_en cycles.
- Start timeout: req[2]=1, port 2 never raises rx_dv. Required: gnt[2] held 16 cycles, then err_timeout pulses once, gnt=0, and the next grant goes to port 3 if it is requesting.
- Overlength: MAX_LEN=8, port 1 sends 12 bytes. Required: exactly 8 bytes on txd; err_overlen pulses once; bytes 9..12 are never visible.
- Isolation and reset: port 0 granted mid-frame while port 3 toggles rx_dv with rxd=0xFF. Required: 0xFF never appears on txd. Then assert rst mid-frame. Required: next cycle tx_en=0, gnt=0, rr_ptr=0.
